// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register slice.
// Holds the default bundle widths, the NOP control encoding and the
// saturating counter helper used by the stage statistics counters.
package pipe_pkg;

  localparam int CTRL_W_DEF = 14;
  localparam int DATA_W_DEF = 128;
  localparam int PC_W       = 30;
  localparam int CNT_W_DEF  = 16;

  // All-zero control bundle: no register, memory or CP0 write can happen.
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Increment-with-ceiling on a 64-bit view of a counter; callers cast the
  // result back to their own counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_val,
                                          input logic        inc);
    if (inc && (value != max_val)) begin
      return value + 64'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register used as the second slot of an elastic stage.
// Ports:
//   Clk, Rst_n        falling-edge clock, asynchronous active-low reset
//   load              capture in_ctrl/in_data/in_pc and mark the entry valid
//   clr               drop the entry (valid, ctrl and pc zeroed, data held)
//   in_ctrl/data/pc   entry to capture
//   valid/ctrl/data/pc  stored entry
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc
);

  // Clearing wins over loading so a kill can never be overridden; the
  // data field is left alone because nothing downstream trusts it once
  // the entry is invalid.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      pc    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries a control bundle, a data bundle and PC[31:2] between stages with
// a valid/ready handshake, an optional skid slot, flush > bubble priority
// and saturating stall/bubble counters. Registers update on the falling
// edge of Clk.
// Ports:
//   Clk, Rst_n                      clock (falling edge), async active-low reset
//   in_valid/in_ready               upstream handshake
//   in_ctrl/in_data/in_pc           upstream entry
//   bubble                          refuse input and insert a NOP downstream
//   flush                           kill every entry held in the stage
//   out_valid/out_ready             downstream handshake
//   out_ctrl/out_data/out_pc        entry presented downstream
//   cnt_clr                         synchronous clear of both counters
//   stall_cnt/bubble_cnt            saturating statistics counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CTRL_W-1:0] NOP     = CTRL_W'(CTRL_NOP);
  localparam logic [63:0]       CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [PC_W-1:0]   main_pc;

  logic              main_valid_nxt;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic [DATA_W-1:0] main_data_nxt;
  logic [PC_W-1:0]   main_pc_nxt;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [PC_W-1:0]   skid_pc;

  logic              main_free;
  logic              in_xfer;
  logic              stall_hit;
  logic              bubble_hit;
  logic              slot_open;
  logic [CNT_W-1:0]  stall_nxt;
  logic [CNT_W-1:0]  bubble_nxt;

  // Main is free when it is empty or its entry leaves at this edge.
  assign main_free = ~main_valid | out_ready;

  // With a skid slot the ready depends only on stored state; without it
  // the upstream sees the downstream ready combinationally.
  assign slot_open = (SKID != 0) ? ~skid_valid : main_free;
  assign in_ready  = Rst_n & ~flush & ~bubble & slot_open;
  assign in_xfer   = in_valid & in_ready;

  assign stall_hit  = main_valid & ~out_ready;
  // A skid entry waiting to move into main takes the slot instead of a NOP.
  assign bubble_hit = bubble & ~flush & main_free & ~skid_valid;

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_pc    = main_valid ? main_pc : '0;
  assign out_data  = main_data;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clr;

      // Only park in the skid slot when main is still occupied, so at most
      // one register is written from in_* per edge and order is kept.
      assign skid_load = in_xfer & ~main_free;
      assign skid_clr  = flush | (skid_valid & main_free);

      pipe_skid_buf #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
      ) u_skid (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .load   (skid_load),
        .clr    (skid_clr),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .in_pc  (in_pc),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data),
        .pc     (skid_pc)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign skid_pc    = '0;
    end
  endgenerate

  // Main register next state. A bubble never accepts input, so the same
  // refill order (skid, then upstream, else empty) covers bubble and normal
  // operation; an emptied main always carries a NOP control bundle.
  always_comb begin
    main_valid_nxt = main_valid;
    main_ctrl_nxt  = main_ctrl;
    main_data_nxt  = main_data;
    main_pc_nxt    = main_pc;
    if (flush) begin
      main_valid_nxt = 1'b0;
      main_ctrl_nxt  = NOP;
      main_pc_nxt    = '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid_nxt = 1'b1;
        main_ctrl_nxt  = skid_ctrl;
        main_data_nxt  = skid_data;
        main_pc_nxt    = skid_pc;
      end else if (in_xfer) begin
        main_valid_nxt = 1'b1;
        main_ctrl_nxt  = in_ctrl;
        main_data_nxt  = in_data;
        main_pc_nxt    = in_pc;
      end else begin
        main_valid_nxt = 1'b0;
        main_ctrl_nxt  = NOP;
        main_pc_nxt    = '0;
      end
    end
  end

  // Main register state.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      main_pc    <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      main_ctrl  <= main_ctrl_nxt;
      main_data  <= main_data_nxt;
      main_pc    <= main_pc_nxt;
    end
  end

  // Saturating increments for the statistics counters.
  always_comb begin
    stall_nxt  = CNT_W'(sat_inc(64'(stall_cnt), CNT_MAX, stall_hit));
    bubble_nxt = CNT_W'(sat_inc(64'(bubble_cnt), CNT_MAX, bubble_hit));
  end

  // Counter registers; a clear beats a coincident increment.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= stall_nxt;
      bubble_cnt <= bubble_nxt;
    end
  end

endmodule
